// File: rtl/text_pkg.sv
// Shared constants and types for the text grid writer, character RAM and VGA renderer.
// Grid geometry defaults and the control codes recognised from the keypad encoder.
package text_pkg;

    localparam int GRID_COL_DEF = 10;
    localparam int GRID_ROW_DEF = 5;
    localparam int ADDR_W_DEF   = 6;

    localparam logic [6:0] ASCII_SPACE = 7'd32;
    localparam logic [6:0] ASCII_BS    = 7'd8;
    localparam logic [6:0] ASCII_LF    = 7'd10;
    localparam logic [6:0] ASCII_FF    = 7'd12;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W_DEF = width_of(GRID_COL_DEF);
    localparam int ROW_W_DEF = width_of(GRID_ROW_DEF);
    localparam int CELLS_DEF = GRID_COL_DEF * GRID_ROW_DEF;

endpackage

// File: rtl/text_grid_writer_pulse_sync.sv
// Brings the encoder's level strobe into clk_pix and turns each rising edge
// into a single-cycle pulse.
module pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_pix,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic [STAGES-1:0] sync_reg;
    logic              last_reg;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], level};
            last_reg <= sync_reg[STAGES-1];
        end
    end

    // Combinational so the event is visible in the cycle after the second flop captures it.
    assign pulse = sync_reg[STAGES-1] & ~last_reg;

endmodule

// File: rtl/text_grid_writer.sv
// Cursor-driven writer into the character RAM: prints glyphs, handles backspace,
// newline and a full-screen clear sweep.
module text_grid_writer
    import text_pkg::*;
#(
    parameter int GRID_COL = GRID_COL_DEF,
    parameter int GRID_ROW = GRID_ROW_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                          clk_pix,
    input  logic                          rst,
    input  logic [6:0]                    ascii_in,
    input  logic                          write_en,
    input  logic                          ctrl_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [6:0]                    ram_data,
    output logic [width_of(GRID_COL)-1:0] cursor_col,
    output logic [width_of(GRID_ROW)-1:0] cursor_row,
    output logic                          busy
);

    localparam int COL_W = width_of(GRID_COL);
    localparam int ROW_W = width_of(GRID_ROW);
    localparam int CELLS = GRID_COL * GRID_ROW;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(GRID_COL - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(GRID_ROW - 1);

    logic key_event;

    pulse_sync #(
        .STAGES(2)
    ) u_sync (
        .clk_pix(clk_pix),
        .rst    (rst),
        .level  (write_en),
        .pulse  (key_event)
    );

    state_t            state_reg;
    logic [ADDR_W-1:0] sweep_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [6:0]        ram_data_reg;
    logic              busy_reg;

    logic [ADDR_W-1:0] cell_addr;
    logic [ADDR_W-1:0] back_addr;
    logic [COL_W-1:0]  adv_col;
    logic [ROW_W-1:0]  adv_row;
    logic [ROW_W-1:0]  down_row;
    logic [COL_W-1:0]  back_col;
    logic [ROW_W-1:0]  back_row;

    always_comb begin
        cell_addr = ADDR_W'(int'(row_reg) * GRID_COL + int'(col_reg));
        down_row  = (row_reg == LAST_ROW) ? '0 : row_reg + ROW_W'(1);

        adv_col = col_reg + COL_W'(1);
        adv_row = row_reg;
        if (col_reg == LAST_COL) begin
            adv_col = '0;
            adv_row = down_row;
        end

        // Backspace saturates at the home cell rather than wrapping to the end.
        back_col = col_reg - COL_W'(1);
        back_row = row_reg;
        if (col_reg == '0) begin
            if (row_reg == '0) begin
                back_col = '0;
            end else begin
                back_col = LAST_COL;
                back_row = row_reg - ROW_W'(1);
            end
        end
        back_addr = ADDR_W'(int'(back_row) * GRID_COL + int'(back_col));
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_reg    <= CLEAR;
            sweep_reg    <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_data_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            ram_we_reg <= 1'b0;
            busy_reg   <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    ram_we_reg   <= 1'b1;
                    ram_addr_reg <= sweep_reg;
                    ram_data_reg <= ASCII_SPACE;
                    busy_reg     <= 1'b1;
                    if (sweep_reg == LAST_ADDR) begin
                        sweep_reg <= '0;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        sweep_reg <= sweep_reg + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    // busy_reg is still high in the cycle just after a sweep, so that event is dropped too.
                    if (key_event && !busy_reg) begin
                        if (!ctrl_en && ascii_in >= ASCII_SPACE) begin
                            ram_we_reg   <= 1'b1;
                            ram_addr_reg <= cell_addr;
                            ram_data_reg <= ascii_in;
                            col_reg      <= adv_col;
                            row_reg      <= adv_row;
                        end else if (ctrl_en && ascii_in == ASCII_BS) begin
                            ram_we_reg   <= 1'b1;
                            ram_addr_reg <= back_addr;
                            ram_data_reg <= ASCII_SPACE;
                            col_reg      <= back_col;
                            row_reg      <= back_row;
                        end else if (ctrl_en && ascii_in == ASCII_LF) begin
                            col_reg <= '0;
                            row_reg <= down_row;
                        end else if (ctrl_en && ascii_in == ASCII_FF) begin
                            // First sweep write issues now so the sweep lasts exactly CELLS cycles.
                            ram_we_reg   <= 1'b1;
                            ram_addr_reg <= '0;
                            ram_data_reg <= ASCII_SPACE;
                            busy_reg     <= 1'b1;
                            sweep_reg    <= ADDR_W'(1);
                            state_reg    <= CLEAR;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_data   = ram_data_reg;
    assign cursor_col = col_reg;
    assign cursor_row = row_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_text_grid_writer.sv
// Directed-plus-random bench for text_grid_writer against a linear-cursor reference model.
module tb_text_grid_writer;
    import text_pkg::*;

    localparam int GC    = GRID_COL_DEF;
    localparam int GR    = GRID_ROW_DEF;
    localparam int CELLS = GC * GR;

    logic                 clk_pix  = 1'b0;
    logic                 rst      = 1'b1;
    logic [6:0]           ascii_in = '0;
    logic                 write_en = 1'b0;
    logic                 ctrl_en  = 1'b0;
    logic                 ram_we;
    logic [ADDR_W_DEF-1:0] ram_addr;
    logic [6:0]           ram_data;
    logic [COL_W_DEF-1:0] cursor_col;
    logic [ROW_W_DEF-1:0] cursor_row;
    logic                 busy;

    text_grid_writer dut (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .ascii_in  (ascii_in),
        .write_en  (write_en),
        .ctrl_en   (ctrl_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    always #5 clk_pix = ~clk_pix;

    int total = 0;
    int bad   = 0;
    int pos   = 0;
    int wr_addr_q[$];
    int wr_data_q[$];

    always @(posedge clk_pix) begin
        #1;
        if (ram_we === 1'b1) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(int'(ram_data));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cursor as a linear cell index; rows and columns are derived only for comparison.
    task automatic model(input int a, input bit c, output bit we, output int addr, output int data);
        we = 1'b0;
        addr = 0;
        data = 0;
        if (!c && a >= 32) begin
            we = 1'b1; addr = pos; data = a;
            pos = (pos + 1) % CELLS;
        end else if (c && a == 8) begin
            if (pos > 0) pos = pos - 1;
            we = 1'b1; addr = pos; data = 32;
        end else if (c && a == 10) begin
            pos = ((pos / GC + 1) % GR) * GC;
        end
    endtask

    task automatic key(input int a, input bit c, input int hold);
        bit we;
        int addr, data;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk_pix);
        ascii_in = 7'(a);
        ctrl_en  = c;
        write_en = 1'b1;
        repeat (hold) @(negedge clk_pix);
        write_en = 1'b0;
        repeat (5) @(negedge clk_pix);
        model(a, c, we, addr, data);
        chk("key_write_count", wr_addr_q.size(), we ? 1 : 0);
        if (we && wr_addr_q.size() > 0) begin
            chk("key_addr", wr_addr_q[0], addr);
            chk("key_data", wr_data_q[0], data);
        end
        chk("key_col", cursor_col, pos % GC);
        chk("key_row", cursor_row, pos / GC);
        $display("key ascii=%0d ctrl=%0d writes=%0d cursor=(%0d,%0d)",
                 a, c, wr_addr_q.size(), cursor_row, cursor_col);
    endtask

    function automatic int sweep_errs();
        int e = 0;
        if (wr_addr_q.size() != CELLS) return -1;
        for (int i = 0; i < CELLS; i++) begin
            if (wr_addr_q[i] != i || wr_data_q[i] != 32) e++;
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},   ram_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_data"}, ram_data, 0);
        chk({tag, "_col"},  cursor_col, 0);
        chk({tag, "_row"},  cursor_row, 0);
    endtask

    initial begin
        int lat;
        bit found;
        bit we;
        int addr, data;
        int r, code;

        // Reset and power-up sweep
        repeat (4) @(negedge clk_pix);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clk_pix);
            chk("sweep_busy", busy, 1);
            chk("sweep_we", ram_we, 1);
            chk("sweep_addr", ram_addr, i);
            chk("sweep_data", ram_data, 32);
        end
        @(negedge clk_pix);
        chk("sweep_end_busy", busy, 0);
        chk("sweep_end_we", ram_we, 0);
        chk("sweep_end_col", cursor_col, 0);
        chk("sweep_end_row", cursor_row, 0);
        $display("power-up sweep finished");

        // First key: latency and single event while held
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk_pix);
        ascii_in = 7'd65;
        ctrl_en  = 1'b0;
        write_en = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int n = 1; n <= 8 && !found; n++) begin
            @(posedge clk_pix);
            #1;
            if (ram_we === 1'b1) begin
                found = 1'b1;
                lat = n;
            end
        end
        chk("first_latency", lat, 3);
        repeat (100) @(negedge clk_pix);
        write_en = 1'b0;
        repeat (5) @(negedge clk_pix);
        model(65, 1'b0, we, addr, data);
        chk("hold_single_write", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            chk("first_addr", wr_addr_q[0], addr);
            chk("first_data", wr_data_q[0], data);
        end
        chk("first_col", cursor_col, pos % GC);
        chk("first_row", cursor_row, pos / GC);
        $display("first key written, cursor=(%0d,%0d)", cursor_row, cursor_col);

        // Fill the first row, spill to row 1, then wrap the whole grid
        for (int i = 0; i < 9; i++) key($urandom_range(32, 127), 1'b0, $urandom_range(1, 6));
        chk("row_end_row", cursor_row, 1);
        chk("row_end_col", cursor_col, 0);
        key($urandom_range(32, 127), 1'b0, 2);
        if (wr_addr_q.size() > 0) chk("eleventh_addr", wr_addr_q[0], 10);
        for (int i = 0; i < 39; i++) key($urandom_range(32, 127), 1'b0, $urandom_range(1, 6));
        chk("wrap_row", cursor_row, 0);
        chk("wrap_col", cursor_col, 0);

        // Backspace across a row boundary and at home
        for (int i = 0; i < GC; i++) key($urandom_range(32, 127), 1'b0, 2);
        key(8, 1'b1, 2);
        if (wr_addr_q.size() > 0) chk("bs_row_cross_addr", wr_addr_q[0], 9);
        chk("bs_row_cross_col", cursor_col, 9);
        for (int i = 0; i < 9; i++) key(8, 1'b1, $urandom_range(1, 6));
        key(8, 1'b1, 3);
        if (wr_addr_q.size() > 0) chk("bs_home_addr", wr_addr_q[0], 0);
        chk("bs_home_col", cursor_col, 0);

        // Newline from the last row wraps to row 0
        for (int i = 0; i < 43; i++) key($urandom_range(32, 127), 1'b0, $urandom_range(1, 4));
        chk("pre_lf_row", cursor_row, 4);
        chk("pre_lf_col", cursor_col, 3);
        key(10, 1'b1, 3);

        // Random mix of printable, control and ignored codes
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1: key($urandom_range(32, 127), 1'b0, $urandom_range(1, 6));
                2:    key(8, 1'b1, $urandom_range(1, 6));
                3:    key(10, 1'b1, $urandom_range(1, 6));
                4:    key($urandom_range(0, 31), 1'b0, $urandom_range(1, 6));
                default: begin
                    code = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(13, 127);
                    key(code, 1'b1, $urandom_range(1, 6));
                end
            endcase
        end

        // Clear command with a key pressed during the sweep
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk_pix);
        ascii_in = 7'd12;
        ctrl_en  = 1'b1;
        write_en = 1'b1;
        repeat (3) @(negedge clk_pix);
        write_en = 1'b0;
        repeat (8) @(negedge clk_pix);
        chk("clear_busy", busy, 1);
        ascii_in = 7'd90;
        ctrl_en  = 1'b0;
        write_en = 1'b1;
        repeat (4) @(negedge clk_pix);
        write_en = 1'b0;
        for (int n = 0; n < 100 && busy === 1'b1; n++) @(negedge clk_pix);
        chk("clear_done", busy, 0);
        repeat (8) @(negedge clk_pix);
        chk("clear_sweep_errs", sweep_errs(), 0);
        pos = 0;
        chk("clear_col", cursor_col, 0);
        chk("clear_row", cursor_row, 0);
        $display("clear sweep writes=%0d", wr_addr_q.size());

        // Reset in the middle of a sweep
        key($urandom_range(32, 127), 1'b0, 2);
        @(negedge clk_pix);
        ascii_in = 7'd12;
        ctrl_en  = 1'b1;
        write_en = 1'b1;
        repeat (2) @(negedge clk_pix);
        write_en = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk_pix);
            #1;
            if (ram_we === 1'b1 && ram_addr == 20) found = 1'b1;
        end
        chk("reach_addr20", found, 1);
        rst = 1'b1;
        @(posedge clk_pix);
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk_pix);
        wr_addr_q.delete();
        wr_data_q.delete();
        rst = 1'b0;
        repeat (60) @(negedge clk_pix);
        chk("restart_sweep_errs", sweep_errs(), 0);
        chk("restart_busy", busy, 0);
        pos = 0;
        $display("sweep restarted after reset, writes=%0d", wr_addr_q.size());

        key($urandom_range(32, 127), 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_grid_writer.md
Name: text_grid_writer

Overview:
- Consumer end of the keypad character encoder.
- Takes the encoder's asynchronous-level write strobe, 7-bit ASCII code and control qualifier, and synchronises them into clk_pix.
- Maintains a cursor over a GRID_COL x GRID_ROW character grid and issues single-cycle writes to the character RAM that the VGA dot-matrix renderer reads.
- Handles printable characters, backspace, newline and clear-screen.

Parameters:
- GRID_COL, 10, characters per row.
- GRID_ROW, 5, rows in the grid.
- ADDR_W, 6, character RAM address width; must satisfy 2**ADDR_W >= GRID_COL*GRID_ROW.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- ascii_in  in  7  character code from the encoder. 0 means no key.
- write_en  in  1  level strobe from the encoder, asynchronous to clk_pix. High while a key is held.
- ctrl_en  in  1  when high, ascii_in is a control code and not a glyph.
- ram_we  out  1  character RAM write enable, one-cycle pulse.
- ram_addr  out  ADDR_W  write address, computed as row*GRID_COL + col.
- ram_data  out  7  character written.
- cursor_col  out  ceil(log2(GRID_COL))  current column.
- cursor_row  out  ceil(log2(GRID_ROW))  current row.
- busy  out  1  high while a clear sweep is running.

Behaviour:
- Clocking and reset:
  - One clock, clk_pix. Reset is synchronous and active-high.
  - While rst is high: ram_we=0, ram_addr=0, ram_data=0, cursor=(0,0), busy=0, synchroniser flops=0, state=CLEAR_INIT.
- Input synchronisation:
  - write_en passes through a 2-flop synchroniser, then a rising-edge detector.
  - If write_en is high before edge k, the edge is detected combinationally after edge k+1.
  - ascii_in and ctrl_en are sampled at edge k+2, by which time they are stable.
  - No debounce. Holding a key produces exactly one event. Release produces none.
- State machine (IDLE, CLEAR):
  - CLEAR_INIT is CLEAR with sweep address 0, entered from reset. busy=1 from the first cycle after rst deasserts.
  - IDLE, with a detected event, acts on the decoded action:
    - Printable (ctrl_en=0, ascii_in in 32..127):
      - At edge k+2: ram_we=1, ram_addr=current cell, ram_data=ascii_in.
      - Cursor advances at the same edge.
      - Advance rule: col+1; at col=GRID_COL-1, col=0 and row+1; at the last cell, wrap to (0,0).
    - Backspace (ctrl_en=1, ascii_in=8):
      - Cursor moves back one cell. From (0,0) it stays put.
      - From col=0, row>0 it goes to (row-1, GRID_COL-1).
      - Writes 32 (space) to the new cell at the same edge.
    - Newline (ctrl_en=1, ascii_in=10): col=0, row+1, wrapping to row 0. No RAM write.
    - Clear (ctrl_en=1, ascii_in=12): enter CLEAR.
    - Anything else is ignored, with no write and no cursor change. This includes ascii_in=0, codes 1..31 with ctrl_en=0, and unknown control codes.
  - CLEAR:
    - Writes 32 to addresses 0..GRID_COL*GRID_ROW-1, one per cycle, with ram_we=1 every cycle.
    - busy=1 throughout.
    - After the last address: cursor=(0,0), busy=0, ram_we=0, return to IDLE.
    - Duration is exactly GRID_COL*GRID_ROW cycles.
- Events detected while busy=1 are dropped, not queued.
- ram_we is 0 in every cycle with no write. ram_addr and ram_data hold their last values when idle.
- rst mid-CLEAR or mid-write aborts immediately, then restarts the clear sweep from address 0.
- Address arithmetic is unsigned and never exceeds GRID_COL*GRID_ROW-1.

Decomposition:
- Shared package text_pkg:
  - GRID_COL and GRID_ROW defaults.
  - ASCII constants: SPACE=32, BS=8, LF=10, FF=12.
  - State enum {IDLE, CLEAR}.
  - Address/width helper constants, also used by the VGA renderer and the character RAM.
- One sub-module, pulse_sync: 2-flop synchroniser plus rising-edge detector on clk_pix with the same synchronous reset. It outputs a one-cycle pulse.

Test Plan:
- Reset release -> busy=1 for 50 cycles; ram_we=1 with ram_addr 0..49 and ram_data=32 on each; then busy=0 and cursor=(0,0).
- After clear, write_en rises with ascii_in=65, ctrl_en=0 -> exactly one ram_we pulse 3 edges later, ram_addr=0, ram_data=65; cursor=(0,1); holding write_en for 100 cycles gives no further write.
- Ten printable keys then one more -> 10th write at addr 9, cursor=(1,0); 11th at addr 10. 50 keys -> cursor wraps to (0,0).
- Cursor (1,0), backspace -> cursor=(0,9), write addr 9 data 32. At (0,0), backspace -> cursor stays (0,0), write addr 0 data 32.
- Cursor (4,3), newline -> cursor=(0,0) with no ram_we. Then clear (ascii 12, ctrl_en=1) -> 50-cycle sweep; a key pressed during the sweep produces no write.
- rst asserted at sweep address 20 -> outputs return to reset values; after release the sweep restarts at address 0.
